// File: rtl/freq_meter_ctrl_pkg.sv
// Shared types for the frequency-meter gate controller: FSM encoding, range codes
// and the range -> gate-length mapping.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_LATCH
  } state_t;

  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;

  function automatic int unsigned gate_len(input logic [1:0] r, input int unsigned clk_hz);
    case (r)
      RANGE_1S:    return clk_hz;
      RANGE_100MS: return clk_hz / 10;
      default:     return clk_hz / 100;
    endcase
  endfunction

  // Code 3 has no gate of its own; treat it as the shortest window.
  function automatic logic [1:0] clamp_range(input logic [1:0] r);
    return (r == 2'd3) ? RANGE_10MS : r;
  endfunction

endpackage

// File: rtl/freq_meter_ctrl_if.sv
// Counter-control and result bundle between the gate controller (master) and
// the BCD counter / display side (slave).
interface freq_meter_ctrl_if;
  logic        cnt_enable;
  logic        cnt_reset_n;
  logic [15:0] count_in;
  logic [15:0] latched;
  logic [1:0]  range;
  logic        valid;

  modport master (
    output cnt_enable, cnt_reset_n, latched, range, valid,
    input  count_in
  );

  modport slave (
    input  cnt_enable, cnt_reset_n, latched, range, valid,
    output count_in
  );
endinterface

// File: rtl/freq_meter_ctrl_range_selector.sv
// Next-range decision: manual clamp of range_sel, or auto-range with a
// hysteresis band on thousands digits 1..8.
module range_selector
  import freq_meter_pkg::*;
(
  input  logic [1:0] cur_range,
  input  logic [3:0] thousands,
  input  logic       auto_range,
  input  logic [1:0] range_sel,
  output logic [1:0] next_range
);

  always_comb begin
    next_range = cur_range;
    if (!auto_range)
      next_range = clamp_range(range_sel);
    else if (thousands == 4'd9 && cur_range < RANGE_10MS)
      next_range = cur_range + 2'd1;
    else if (thousands == 4'd0 && cur_range > RANGE_1S)
      next_range = cur_range - 2'd1;
  end

endmodule

// File: rtl/freq_meter_ctrl.sv
// Gate/timing controller for the 4-digit BCD frequency meter: clears and gates
// the counter, waits for settling, latches the result and auto-ranges.
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             auto_range,
  input  logic [1:0]       range_sel,
  freq_meter_ctrl_if.master cnt,
  output logic             busy
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer;
  logic [1:0]       wrange, sel_range, clr_range;
  logic             timer_done;

  assign timer_done = (timer == '0);

  range_selector u_rsel (
    .cur_range  (wrange),
    .thousands  (cnt.count_in[15:12]),
    .auto_range (auto_range),
    .range_sel  (range_sel),
    .next_range (sel_range)
  );

  // Range the upcoming gate will use; in auto mode it was already settled in LATCH.
  assign clr_range = auto_range ? wrange : sel_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (run) state_nx = ST_CLEAR;
      ST_CLEAR:  state_nx = ST_GATE;
      ST_GATE:   if (timer_done) state_nx = ST_SETTLE;
      ST_SETTLE: if (timer_done) state_nx = ST_LATCH;
      ST_LATCH:  state_nx = run ? ST_CLEAR : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Timer holds remaining cycles minus one of the current GATE/SETTLE phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else begin
      case (state)
        ST_CLEAR:  timer <= CNT_W'(gate_len(clr_range, CLK_HZ) - 1);
        ST_GATE:   timer <= timer_done ? CNT_W'(SETTLE_CYCLES - 1) : timer - 1'b1;
        ST_SETTLE: if (!timer_done) timer <= timer - 1'b1;
        default:   timer <= '0;
      endcase
    end
  end

  // Counter controls are flops off the next state so the gate edge is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt.cnt_enable  <= 1'b0;
      cnt.cnt_reset_n <= 1'b0;
      busy            <= 1'b0;
    end else begin
      cnt.cnt_enable  <= (state_nx == ST_GATE);
      cnt.cnt_reset_n <= (state_nx == ST_GATE) || (state_nx == ST_SETTLE) ||
                         (state_nx == ST_LATCH);
      busy            <= (state_nx != ST_IDLE);
    end
  end

  // valid is raised together with the new latched/range so the display sees them coherent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt.latched <= 16'h0000;
      cnt.range   <= RANGE_1S;
      cnt.valid   <= 1'b0;
      wrange      <= RANGE_1S;
    end else begin
      cnt.valid <= (state == ST_LATCH);
      if (state == ST_CLEAR && !auto_range)
        wrange <= sel_range;
      if (state == ST_LATCH) begin
        cnt.latched <= cnt.count_in;
        cnt.range   <= wrange;
        if (auto_range) wrange <= sel_range;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl: scoreboard of expected results checked on
// each valid pulse, plus reset, run-drop, auto-range and clamp scenarios.
module tb_freq_meter_ctrl;
  localparam int CLK_HZ = 1000;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       auto_range = 1'b0;
  logic [1:0] range_sel = 2'd0;
  logic       busy;

  freq_meter_ctrl_if bus();

  freq_meter_ctrl #(.CLK_HZ(CLK_HZ), .SETTLE_CYCLES(SETTLE), .CNT_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .auto_range (auto_range),
    .range_sel  (range_sel),
    .cnt        (bus),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [1:0]  rng;
    int          gate;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0, errors = 0;
  int   valid_cnt = 0, pushes = 0;
  int   cyc = 0, clr_cyc = 0, gate_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gate_of(input logic [1:0] r);
    return (r == 2'd0) ? CLK_HZ : (r == 2'd1) ? CLK_HZ / 10 : CLK_HZ / 100;
  endfunction

  function automatic logic [1:0] model_next(input logic [1:0] r, input logic [3:0] d);
    if (d == 4'd9 && r < 2'd2) return r + 2'd1;
    if (d == 4'd0 && r > 2'd0) return r - 2'd1;
    return r;
  endfunction

  task automatic push(input logic [15:0] bcd, input logic [1:0] rng);
    exp_t e;
    e.bcd  = bcd;
    e.rng  = rng;
    e.gate = gate_of(rng);
    sb.push_back(e);
    pushes++;
  endtask

  task automatic wait_valid(input int bound);
    int start;
    int n;
    start = valid_cnt;
    n = 0;
    while (valid_cnt == start && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(valid_cnt != start), 32'd1);
  endtask

  // Monitor: gate length, CLEAR-to-valid period and result fields per measurement.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      gate_cnt = 0;
    end else begin
      if (bus.valid) begin
        valid_cnt++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          chk("latched", 32'(bus.latched), 32'(cur.bcd));
          chk("range", 32'(bus.range), 32'(cur.rng));
          chk("gate_len", gate_cnt, cur.gate);
          chk("period", cyc - clr_cyc, cur.gate + SETTLE + 2);
        end
      end
      if (busy && !bus.cnt_reset_n) begin
        clr_cyc  = cyc;
        gate_cnt = 0;
      end
      if (bus.cnt_enable) gate_cnt++;
    end
  end

  logic [15:0] tbl [7];
  logic [1:0]  r;

  initial begin
    bus.count_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_en",     32'(bus.cnt_enable),  32'd0);
    chk("rst_clr_n",  32'(bus.cnt_reset_n), 32'd0);
    chk("rst_latch",  32'(bus.latched),     32'd0);
    chk("rst_range",  32'(bus.range),       32'd0);
    chk("rst_valid",  32'(bus.valid),       32'd0);
    chk("rst_busy",   32'(busy),            32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy",  32'(busy),            32'd0);

    // Manual 1 s measurement with run dropped at gate cycle 500.
    bus.count_in = 16'h0437;
    push(16'h0437, 2'd0);
    run = 1'b1;
    for (int n = 0; n < 20 && !bus.cnt_enable; n++) @(negedge clk);
    chk("gate_start", 32'(bus.cnt_enable), 32'd1);
    repeat (499) @(negedge clk);
    run = 1'b0;
    wait_valid(2000);
    @(negedge clk);
    chk("drop_busy",  32'(busy),            32'd0);
    chk("drop_clr_n", 32'(bus.cnt_reset_n), 32'd0);
    chk("drop_en",    32'(bus.cnt_enable),  32'd0);
    repeat (20) @(negedge clk);
    chk("single_valid", valid_cnt, 1);

    // Reset mid-gate, then restart straight into CLEAR.
    range_sel = 2'd1;
    bus.count_in = 16'h0250;
    run = 1'b1;
    for (int n = 0; n < 20 && !bus.cnt_enable; n++) @(negedge clk);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_en",     32'(bus.cnt_enable),  32'd0);
    chk("mid_clr_n",  32'(bus.cnt_reset_n), 32'd0);
    chk("mid_latch",  32'(bus.latched),     32'd0);
    chk("mid_range",  32'(bus.range),       32'd0);
    chk("mid_valid",  32'(bus.valid),       32'd0);
    chk("mid_busy",   32'(busy),            32'd0);
    push(16'h0250, 2'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("clr_busy",   32'(busy),            32'd1);
    chk("clr_clr_n",  32'(bus.cnt_reset_n), 32'd0);
    chk("clr_en",     32'(bus.cnt_enable),  32'd0);
    run = 1'b0;
    @(negedge clk);
    chk("gate_en",    32'(bus.cnt_enable),  32'd1);
    wait_valid(500);

    // Auto-range sequence from range 0, back-to-back measurements.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    auto_range = 1'b1;
    tbl = '{16'h9123, 16'h9999, 16'h9001, 16'h0042, 16'h0500, 16'h0003, 16'h0003};
    r = 2'd0;
    push(tbl[0], r);
    bus.count_in = tbl[0];
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid(2500);
      r = model_next(r, tbl[i][15:12]);
      if (i < 6) begin
        push(tbl[i+1], r);
        bus.count_in = tbl[i+1];
        if (i == 5) run = 1'b0;
      end
    end
    @(negedge clk);
    chk("auto_idle",  32'(busy),            32'd0);

    // Manual range_sel=3 is clamped to the 10 ms window.
    auto_range = 1'b0;
    range_sel = 2'd3;
    bus.count_in = 16'h0777;
    push(16'h0777, 2'd2);
    run = 1'b1;
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    run = 1'b0;
    wait_valid(200);

    repeat (5) @(negedge clk);
    chk("sb_empty",    32'(sb.size()), 32'd0);
    chk("valid_total", valid_cnt, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
